// File: rtl/plic_lite.sv
// plic_lite: single-context platform-level interrupt controller.
// Level-sensitive sources pass through a gateway (pending/in-flight) and are
// arbitrated by priority against a threshold. Firmware claims and completes
// interrupts through a small word-addressed register window on the D-bus.
//
// Bus handshake: a request is accepted in IDLE when bus_ss & bus_bstart are
// both high. The block then spends exactly one cycle in RESP, where bus_done
// is high and bus_rdata carries read data. Register side effects land on the
// clock edge that ends RESP. bus_bstart is ignored while in RESP.
module plic_lite #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_W     = 3,
    parameter int BASE_OFS_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic                  bus_ss,
    input  logic                  bus_bstart,
    input  logic                  bus_write,
    input  logic [BASE_OFS_W-1:0] bus_addr,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic                  bus_done,
    output logic                  irq_ext
);

    localparam int ID_W = $clog2(NUM_SRC);
    localparam int WA_W = BASE_OFS_W - 2;

    // Word addresses (byte offset >> 2) of the fixed registers.
    localparam logic [WA_W-1:0] WA_PEND  = WA_W'(32'h020);
    localparam logic [WA_W-1:0] WA_EN    = WA_W'(32'h040);
    localparam logic [WA_W-1:0] WA_THR   = WA_W'(32'h080);
    localparam logic [WA_W-1:0] WA_CLAIM = WA_W'(32'h081);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

    bus_state_t          state;
    logic                req_write;
    logic [WA_W-1:0]     req_word;
    logic [31:0]         req_wdata;

    logic [PRIO_W-1:0]   prio [NUM_SRC];
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  enable;
    logic [NUM_SRC-1:0]  inflight;
    logic [PRIO_W-1:0]   threshold;

    logic                sel_pend;
    logic                sel_en;
    logic                sel_thr;
    logic                sel_claim;
    logic [NUM_SRC-1:0]  sel_prio;
    logic                wr_fire;
    logic                rd_fire;
    logic                claim_fire;
    logic                complete_fire;

    logic [ID_W-1:0]     best_id;
    logic [PRIO_W-1:0]   best_prio;
    logic [31:0]         rdata_mux;

    // Byte-lane bits of the address and source 0 carry no meaning here.
    logic                unused_bits;
    assign unused_bits = ^{bus_addr[1:0], irq_src[0]};

    // Bus FSM: accept in IDLE, respond for one cycle in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_done  <= 1'b0;
            req_write <= 1'b0;
            req_word  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_ss && bus_bstart) begin
                        state     <= RESP;
                        bus_done  <= 1'b1;
                        req_write <= bus_write;
                        req_word  <= bus_addr[BASE_OFS_W-1:2];
                        req_wdata <= bus_wdata;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus_done <= 1'b0;
                end
            endcase
        end
    end

    // Address decode of the latched request and the RESP-cycle strobes.
    always_comb begin
        sel_pend  = (req_word == WA_PEND);
        sel_en    = (req_word == WA_EN);
        sel_thr   = (req_word == WA_THR);
        sel_claim = (req_word == WA_CLAIM);
        sel_prio  = '0;
        for (int i = 1; i < NUM_SRC; i++) begin
            sel_prio[i] = (req_word == WA_W'(i));
        end
    end

    assign wr_fire       = (state == RESP) && req_write;
    assign rd_fire       = (state == RESP) && !req_write;
    assign complete_fire = wr_fire && sel_claim;
    // A claim that finds nothing eligible returns 0 and must not touch state.
    assign claim_fire    = rd_fire && sel_claim && (best_id != '0);

    // Arbitration: highest priority above threshold wins, lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) &&
                (prio[i] > best_prio)) begin
                best_id   = ID_W'(i);
                best_prio = prio[i];
            end
        end
    end

    // Read mux; the claim value is taken live so it reflects the RESP cycle.
    always_comb begin
        rdata_mux = '0;
        if (sel_pend)  rdata_mux = 32'(pending);
        if (sel_en)    rdata_mux = 32'(enable);
        if (sel_thr)   rdata_mux = 32'(threshold);
        if (sel_claim) rdata_mux = 32'(best_id);
        for (int i = 1; i < NUM_SRC; i++) begin
            if (sel_prio[i]) rdata_mux = 32'(prio[i]);
        end
    end

    assign bus_rdata = (bus_done && !req_write) ? rdata_mux : 32'h0;

    // Firmware-writable configuration: priorities, enables, threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            threshold <= '0;
        end else if (wr_fire) begin
            if (sel_en)  enable    <= req_wdata[NUM_SRC-1:0] & ~NUM_SRC'(1);
            if (sel_thr) threshold <= req_wdata[PRIO_W-1:0];
            for (int i = 1; i < NUM_SRC; i++) begin
                if (sel_prio[i]) prio[i] <= req_wdata[PRIO_W-1:0];
            end
        end
    end

    // Gateway: pending/in-flight tracking per source; a claim beats a new set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            inflight <= '0;
        end else begin
            pending[0]  <= 1'b0;
            inflight[0] <= 1'b0;
            for (int i = 1; i < NUM_SRC; i++) begin
                if (claim_fire && (best_id == ID_W'(i))) begin
                    pending[i]  <= 1'b0;
                    inflight[i] <= 1'b1;
                end else begin
                    if (complete_fire && (req_wdata == 32'(i)) && inflight[i]) begin
                        inflight[i] <= 1'b0;
                    end
                    if (!pending[i] && !inflight[i] && irq_src[i]) begin
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Registered interrupt request to the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_ext <= 1'b0;
        end else begin
            irq_ext <= (best_id != '0);
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: bus transfers through driver tasks, expected
// read data queued before each transfer and popped when bus_done arrives.
module tb_plic_lite;

  localparam int NUM_SRC = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic        bus_ss;
  logic        bus_bstart;
  logic        bus_write;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_done;
  logic        irq_ext;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  logic [2:0]  mprio [8];
  logic [2:0]  mthr;
  logic [7:0]  mpend;
  logic [2:0]  bp;
  int          best;
  int unsigned rv;

  plic_lite #(
    .NUM_SRC(NUM_SRC),
    .PRIO_W(3),
    .BASE_OFS_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_src(irq_src),
    .bus_ss(bus_ss),
    .bus_bstart(bus_bstart),
    .bus_write(bus_write),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_done(bus_done),
    .irq_ext(irq_ext)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus transfer; checks 1-cycle latency and a single-cycle done pulse.
  task automatic bus_xfer(input logic wr, input logic [9:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    n = 0;
    bus_ss     = 1'b1;
    bus_bstart = 1'b1;
    bus_write  = wr;
    bus_addr   = addr;
    bus_wdata  = wdata;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_done && n < 8);
    chk1("xfer_done", bus_done, 1'b1);
    chk32("xfer_latency", 32'(n), 32'd1);
    rdata      = bus_rdata;
    bus_ss     = 1'b0;
    bus_bstart = 1'b0;
    bus_write  = 1'b0;
    @(posedge clk);
    #1;
    chk1("xfer_done_pulse", bus_done, 1'b0);
    chk32("xfer_rdata_idle", bus_rdata, 32'h0);
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    bus_xfer(1'b0, addr, 32'h0, got);
    chk32(tag, got, exp_q.pop_front());
  endtask

  initial begin
    rst        = 1'b1;
    irq_src    = '0;
    bus_ss     = 1'b0;
    bus_bstart = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // reset state
    chk1("rst_done", bus_done, 1'b0);
    chk1("rst_irq", irq_ext, 1'b0);
    chk32("rst_rdata", bus_rdata, 32'h0);
    rd_chk("rst_prio1", 10'h004, 32'h0);
    rd_chk("rst_pend", 10'h080, 32'h0);
    rd_chk("rst_en", 10'h100, 32'h0);
    rd_chk("rst_thr", 10'h200, 32'h0);
    rd_chk("rst_claim", 10'h204, 32'h0);

    // reset in the middle of a read
    wr(10'h004, 32'd5);
    wr(10'h100, 32'h02);
    wr(10'h200, 32'd1);
    irq_src[1] = 1'b1;
    tick(2);
    irq_src[1] = 1'b0;
    chk1("prerst_irq", irq_ext, 1'b1);
    bus_ss     = 1'b1;
    bus_bstart = 1'b1;
    bus_write  = 1'b0;
    bus_addr   = 10'h100;
    tick(1);
    chk1("midrd_done", bus_done, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrd_done_rst", bus_done, 1'b0);
    chk1("midrd_irq_rst", irq_ext, 1'b0);
    bus_ss     = 1'b0;
    bus_bstart = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk1("postrst_irq", irq_ext, 1'b0);
    rd_chk("postrst_prio1", 10'h004, 32'h0);
    rd_chk("postrst_en", 10'h100, 32'h0);
    rd_chk("postrst_thr", 10'h200, 32'h0);
    rd_chk("postrst_pend", 10'h080, 32'h0);

    // basic claim / complete flow
    wr(10'h00C, 32'd2);
    wr(10'h100, 32'h08);
    wr(10'h200, 32'd0);
    irq_src[3] = 1'b1;
    tick(1);
    chk1("basic_irq_early", irq_ext, 1'b0);
    tick(1);
    chk1("basic_irq", irq_ext, 1'b1);
    rd_chk("basic_pend", 10'h080, 32'h08);
    rd_chk("basic_claim", 10'h204, 32'd3);
    tick(1);
    chk1("basic_irq_drop", irq_ext, 1'b0);
    rd_chk("basic_pend_clr", 10'h080, 32'h0);
    wr(10'h204, 32'd3);
    tick(1);
    rd_chk("basic_pend_reset", 10'h080, 32'h08);
    irq_src[3] = 1'b0;
    rd_chk("basic_claim2", 10'h204, 32'd3);
    wr(10'h204, 32'd3);
    wr(10'h100, 32'h0);

    // arbitration order
    wr(10'h004, 32'd5);
    wr(10'h008, 32'd7);
    wr(10'h010, 32'd7);
    wr(10'h100, 32'h16);
    irq_src = 8'h16;
    tick(2);
    irq_src = 8'h00;
    rd_chk("arb_pend", 10'h080, 32'h16);
    rd_chk("arb_claim_a", 10'h204, 32'd2);
    rd_chk("arb_claim_b", 10'h204, 32'd4);
    rd_chk("arb_claim_c", 10'h204, 32'd1);
    rd_chk("arb_claim_none", 10'h204, 32'd0);
    wr(10'h204, 32'd2);
    wr(10'h204, 32'd4);
    wr(10'h204, 32'd1);
    rd_chk("arb_pend_done", 10'h080, 32'h0);

    // threshold masking
    wr(10'h014, 32'd3);
    wr(10'h200, 32'd3);
    wr(10'h100, 32'h20);
    irq_src[5] = 1'b1;
    tick(2);
    chk1("thr_irq_masked", irq_ext, 1'b0);
    rd_chk("thr_claim_masked", 10'h204, 32'd0);
    wr(10'h200, 32'd2);
    chk1("thr_irq_lat", irq_ext, 1'b0);
    tick(1);
    chk1("thr_irq", irq_ext, 1'b1);
    rd_chk("thr_claim", 10'h204, 32'd5);
    irq_src[5] = 1'b0;
    wr(10'h204, 32'd5);

    // register field corners and unmapped space
    wr(10'h100, 32'hFFFF_FFFF);
    rd_chk("en_bit0", 10'h100, 32'hFE);
    wr(10'h008, 32'hFFFF_FFFF);
    rd_chk("prio_mask", 10'h008, 32'd7);
    wr(10'h200, 32'hFFFF_FFFF);
    rd_chk("thr_mask", 10'h200, 32'd7);
    wr(10'h000, 32'd7);
    rd_chk("prio0", 10'h000, 32'h0);
    wr(10'h020, 32'd7);
    rd_chk("prio_nsrc", 10'h020, 32'h0);
    wr(10'h3FC, 32'h1234);
    rd_chk("unmapped", 10'h3FC, 32'h0);
    wr(10'h080, 32'hFF);
    rd_chk("pend_ro", 10'h080, 32'h0);
    wr(10'h200, 32'd0);
    wr(10'h100, 32'h0);

    // bad completes leave source 6 blocked
    wr(10'h018, 32'd1);
    wr(10'h100, 32'h40);
    irq_src[6] = 1'b1;
    tick(2);
    wr(10'h204, 32'd6);
    rd_chk("bad_pend", 10'h080, 32'h40);
    rd_chk("bad_claim", 10'h204, 32'd6);
    wr(10'h204, 32'd0);
    wr(10'h204, 32'd7);
    wr(10'h204, 32'h106);
    tick(3);
    rd_chk("bad_blocked", 10'h080, 32'h0);
    chk1("bad_irq", irq_ext, 1'b0);
    wr(10'h204, 32'd6);
    tick(1);
    rd_chk("bad_reset", 10'h080, 32'h40);
    irq_src[6] = 1'b0;
    rd_chk("bad_claim2", 10'h204, 32'd6);
    wr(10'h204, 32'd6);
    wr(10'h100, 32'h0);

    // back-to-back write/read pairs
    wr(10'h01C, 32'd4);
    rd_chk("b2b_prio7", 10'h01C, 32'd4);
    wr(10'h200, 32'd5);
    rd_chk("b2b_thr", 10'h200, 32'd5);

    // random priorities: queue expected readback at write time
    for (int i = 1; i < 8; i++) begin
      rv = $urandom_range(0, 255);
      mprio[i] = rv[2:0];
      exp_q.push_back(rv & 32'h7);
      wr(10'(4 * i), rv);
    end
    for (int i = 1; i < 8; i++) begin
      bus_xfer(1'b0, 10'(4 * i), 32'h0, rd);
      chk32($sformatf("rnd_prio%0d", i), rd, exp_q.pop_front());
    end

    // random arbitration against a reference claim order
    rv   = $urandom_range(0, 3);
    mthr = rv[2:0];
    wr(10'h200, 32'(mthr));
    wr(10'h100, 32'hFE);
    irq_src = 8'hFE;
    tick(2);
    irq_src = 8'h00;
    mpend = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      best = 0;
      bp   = 3'd0;
      for (int j = 1; j < 8; j++) begin
        if (mpend[j] && mprio[j] > mthr && mprio[j] > bp) begin
          best = j;
          bp   = mprio[j];
        end
      end
      if (best != 0) mpend[best] = 1'b0;
      exp_q.push_back(32'(best));
      bus_xfer(1'b0, 10'h204, 32'h0, rd);
      chk32($sformatf("rnd_claim%0d", k), rd, exp_q.pop_front());
    end
    for (int j = 1; j < 8; j++) begin
      wr(10'h204, 32'(j));
    end
    rd_chk("rnd_pend_left", 10'h080, 32'(mpend));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Single-context platform-level interrupt controller. Slave on the D-bus; fills the `dbus_if_plic0` slot next to the CLINT.
- Gathers level-sensitive external interrupt sources and arbitrates them by priority and threshold.
- Drives one external-interrupt line into `rv_core` core-0.
- Firmware claims and completes interrupts through memory-mapped registers.

Parameters:
- NUM_SRC, 8, number of source IDs including reserved ID 0; legal range 2..32.
- PRIO_W, 3, priority field width; priority 0 means never interrupt.
- BASE_OFS_W, 10, byte-offset address width decoded inside the block.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- irq_src  input  NUM_SRC  level interrupt sources, already synchronous to clk; bit 0 is ignored.
- bus_ss  input  1  slave select from the D-bus interconnect.
- bus_bstart  input  1  transfer start qualifier.
- bus_write  input  1  1 = write, 0 = read.
- bus_addr  input  BASE_OFS_W  byte offset; word aligned (bits[1:0] ignored).
- bus_wdata  input  32  write data.
- bus_rdata  output  32  read data, valid while bus_done = 1.
- bus_done  output  1  single-cycle transfer completion.
- irq_ext  output  1  external interrupt request to the core.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-high: all state clears immediately on rst = 1 and releases on the next clk edge after rst = 0.
- Reset values:
  - bus_rdata = 0, bus_done = 0, irq_ext = 0.
  - All priority, pending, enable, in-flight and threshold bits = 0.
  - Bus FSM = IDLE.
- Register map (word access only; width/size of bus transfer is ignored):
  - 0x000 + 4*i: priority[i], i = 1..NUM_SRC-1. R/W in the low PRIO_W bits; upper bits read 0. i = 0 and i ≥ NUM_SRC read 0, writes ignored.
  - 0x080: pending vector. Read-only; bit 0 always 0.
  - 0x100: enable vector. R/W; bit 0 is forced to 0.
  - 0x200: threshold. R/W in the low PRIO_W bits.
  - 0x204: claim on read, complete on write.
  - Unmapped offsets: reads return 0, writes are ignored, bus_done is still asserted.
- Bus FSM:
  - IDLE: when bus_ss & bus_bstart, latch the request and go to RESP.
  - RESP: assert bus_done for exactly one cycle with bus_rdata; perform the register side effect on the same edge; return to IDLE.
  - Latency is 1 cycle from the accept edge to bus_done.
  - Back-to-back requests are accepted again in the cycle after RESP.
  - bus_bstart seen in RESP is ignored; the master holds bstart until done.
  - bus_rdata returns to 0 when bus_done = 0.
- Gateway (per source i ≥ 1):
  - pending[i] sets on a clk edge when irq_src[i] = 1, pending[i] = 0 and inflight[i] = 0.
  - pending[i] clears only by a claim.
  - inflight[i] sets on claim and clears on a complete write whose value equals i.
  - A complete with an ID that is not in flight, is 0, or is ≥ NUM_SRC has no effect.
  - If the source is still high after complete, pending re-sets on the following edge.
- Arbitration (combinational, over pending & enable):
  - Eligible means priority[i] > threshold.
  - The winner is the highest priority; ties go to the lowest ID.
  - best_id = 0 when nothing is eligible.
- Claim read:
  - Returns best_id evaluated in the RESP cycle.
  - Clears pending[best_id] and sets inflight[best_id] on the same edge.
  - A claim that returns 0 changes no state.
- irq_ext: registered (best_id != 0); one-cycle latency from the cause to irq_ext.
- Simultaneous events:
  - A claim and a new gateway set of the same ID on the same edge: the claim wins; pending stays 0 because inflight is now 1.
  - Priority, enable or threshold writes take effect on arbitration the cycle after RESP.
- Reset mid-transfer: the FSM returns to IDLE, bus_done drops immediately, and the transfer is lost.

Test Plan:
- Reset: assert rst mid-read → bus_done = 0, irq_ext = 0, all registers read 0 after release.
- Basic flow: priority[3] = 2, enable = 0x08, threshold = 0, irq_src[3] = 1 → pending = 0x08, irq_ext = 1 two edges later; claim reads 3, pending = 0, irq_ext = 0; complete 3 with source still high → pending re-sets to 0x08.
- Arbitration: priorities [1] = 5, [2] = 7, [4] = 7, all enabled and pending → claims return 2, 4, 1 in order.
- Threshold masking: priority[5] = 3, threshold = 3 → irq_ext = 0 and claim returns 0; set threshold = 2 → irq_ext = 1, claim returns 5.
- Bad complete: write 6 to 0x204 while 6 is not in flight, then write 0 → no state change; source 6 stays blocked until a real complete of 6.
- Bus corners: read 0x000, 0x3FC and priority[NUM_SRC] → 0 with bus_done pulse = 1 cycle; back-to-back read/write pairs each get exactly one done.
